mem_req_ctrl: RTL and testbench
===============================

Name: mem_req_ctrl

Overview:
- Request front-end that sits directly upstream of the 16x32 memory block and drives its enable/read_write/address/data_in pins.
- Accepts read/write commands on a valid/ready interface and buffers them in an in-order command FIFO.
- Issues at most one command per cycle to the memory and captures read data on mem_valid_out.
- Returns read responses on a valid/ready interface. Credit-based issue guarantees the response FIFO never overflows.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 32, data width.
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- RSP_DEPTH, 4, read-response FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  command FIFO can accept
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target word
- req_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  read response available
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data
- rsp_addr  out  ADDR_W  address the data came from
- mem_enable  out  1  to memory enable
- mem_read_write  out  1  to memory read_write (1=write)
- mem_address  out  ADDR_W  to memory address
- mem_data_in  out  DATA_W  to memory data_in
- mem_data_out  in  DATA_W  from memory data_out
- mem_valid_out  in  1  from memory valid_out
- busy  out  1  any command queued or read in flight

Behaviour:
- Reset (rst low, async):
  - Both FIFOs are emptied and all counters cleared.
  - mem_enable=0, mem_read_write=0, mem_address=0, mem_data_in=0.
  - rsp_valid=0, rsp_rdata=0, rsp_addr=0, busy=0.
  - req_ready=0 while in reset, 1 from the first cycle after deassertion.
  - Reset mid-operation drops every in-flight read; no response is produced for it. The memory shares rst and is cleared too.
- Command FIFO:
  - Push on req_valid&&req_ready. req_ready = !cmd_full, so there is no push when full even if a pop happens the same cycle.
  - No bypass: a pushed command is poppable at the earliest on the next edge.
- Issue:
  - All mem_* outputs are registered.
  - On an edge where the FIFO is non-empty and the head command is issuable, the head is popped. mem_enable=1 and read_write/address/data_in are loaded for exactly the following cycle.
  - Otherwise mem_enable=0, and the other mem_* outputs hold their last value.
  - A write is always issuable.
  - A read is issuable only if rsp_count + rd_inflight < RSP_DEPTH. rsp_count is the current occupancy; no credit is taken for a same-cycle rsp pop.
  - rd_inflight counts reads popped but not yet captured, range 0..2. It increments on read pop, decrements on mem_valid_out, and does both when both occur in the same cycle.
- Ordering:
  - Strictly in-order with no reordering.
  - A stalled head read blocks later writes.
  - Read-after-write to the same address returns the new data, because the memory commits the write one edge before the following read samples.
- Tag path: the issued read address is delayed one cycle alongside the memory latency so it pairs with mem_valid_out. It is pushed with mem_data_out into the response FIFO.
- Response capture: when mem_valid_out=1, {mem_address_d1, mem_data_out} is pushed into the response FIFO. Overflow is impossible by credit; the bench asserts this.
- Latency: request accepted at edge E0 -> popped E1 -> memory samples E2 -> captured E3. rsp_valid is high in the cycle after E3, i.e. 3 cycles from accept with an idle pipe.
- Response output:
  - rsp_valid = !rsp_empty. rsp_rdata/rsp_addr show the head entry.
  - The head entry is held stable while rsp_valid&&!rsp_ready.
  - Simultaneous push and pop is allowed at any occupancy.
- Writes produce no response.
- busy = !cmd_empty || rd_inflight!=0 || mem_enable.

Decomposition:
- Shared package mem_pkg: ADDR_W, DATA_W, MEM_DEPTH=16, and a cmd_t struct {write, addr, wdata}.
- One sub-module is natural: sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/count). It is instantiated twice: command FIFO and response FIFO.

Test Plan:
- Write addr 3 = 0xDEADBEEF, then read addr 3, rsp_ready=1 -> exactly one response with rsp_addr=3, rsp_rdata=0xDEADBEEF; rsp_valid rises 3 cycles after the read is accepted.
- Back-to-back reads of addrs 0..7 after writing data=addr*0x11111111 -> 8 responses in order with matching data; mem_enable high 8 consecutive cycles.
- rsp_ready=0, 8 reads queued -> exactly 4 reads issued, rsp_valid held with head data stable, req_ready=0 once the command FIFO fills. Release rsp_ready -> all 8 responses in order, none lost.
- Interleave write a5=0x1, read a5, write a5=0x2, read a5 back-to-back -> responses 0x1 then 0x2.
- Assert rst mid-stream with 2 reads in flight -> all outputs reach reset values immediately. No response after release; a following read of any address returns 0x00000000.
- Idle after reset -> mem_enable=0, busy=0, rsp_valid=0 for 20 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths and command/response record types for the memory request front-end.
package mem_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 16;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request, response and memory-pin bundle of mem_req_ctrl; slave is the controller's view.
interface mem_req_ctrl_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] rsp_addr;
  logic              mem_enable;
  logic              mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_valid_out;
  logic              busy;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out, mem_valid_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr,
    output mem_enable, mem_read_write, mem_address, mem_data_in, busy
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_data_out, mem_valid_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr,
    input  mem_enable, mem_read_write, mem_address, mem_data_in, busy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO without bypass; a push while full is only taken when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage is cleared on reset so the head reads as zero when nothing was ever written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// In-order request front-end for the 16x32 memory: command queue, credit-gated issue,
// one-cycle address tag delay and a read-response queue.
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_req_ctrl_if.slave bus
);

  localparam int CCW  = $clog2(CMD_DEPTH) + 1;
  localparam int RCW  = $clog2(RSP_DEPTH) + 1;
  localparam int SUMW = RCW + 1;

  cmd_t              w_cmd_in;
  cmd_t              w_cmd_head;
  logic              w_cmd_push;
  logic              w_cmd_pop;
  logic              w_cmd_full;
  logic              w_cmd_empty;
  logic [CCW-1:0]    w_cmd_count;
  rsp_t              w_rsp_in;
  rsp_t              w_rsp_head;
  logic              w_rsp_pop;
  logic              w_rsp_full;
  logic              w_rsp_empty;
  logic [RCW-1:0]    w_rsp_count;
  logic [SUMW-1:0]   w_credit_used;
  logic              w_head_issuable;
  logic              w_rd_issue;

  logic              r_ready_en;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_mem_addr_d1;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_rd_inflight;

  assign bus.req_ready  = r_ready_en && !w_cmd_full;
  assign w_cmd_push     = bus.req_valid && bus.req_ready;
  assign w_cmd_in.write = bus.req_write;
  assign w_cmd_in.addr  = bus.req_addr;
  assign w_cmd_in.wdata = bus.req_wdata;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmd_push),
    .i_pop   (w_cmd_pop),
    .i_wdata (w_cmd_in),
    .o_rdata (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  // A read may issue only while queued responses plus reads in the memory pipe leave a free slot.
  always_comb begin
    w_credit_used = SUMW'(w_rsp_count) + SUMW'(r_rd_inflight);
    if (w_cmd_empty) begin
      w_head_issuable = 1'b0;
    end else if (w_cmd_head.write) begin
      w_head_issuable = 1'b1;
    end else begin
      w_head_issuable = !w_rsp_full && (w_credit_used < SUMW'(RSP_DEPTH));
    end
    w_cmd_pop  = w_head_issuable;
    w_rd_issue = w_head_issuable && !w_cmd_head.write;
  end

  // Hold req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Memory pins: pulse enable for one cycle per popped command, hold the rest otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_addr   <= ADDR_W'(0);
      r_mem_wdata  <= DATA_W'(0);
    end else if (w_cmd_pop) begin
      r_mem_enable <= 1'b1;
      r_mem_rw     <= w_cmd_head.write;
      r_mem_addr   <= w_cmd_head.addr;
      r_mem_wdata  <= w_cmd_head.wdata;
    end else begin
      r_mem_enable <= 1'b0;
    end
  end

  // Address tag trails the memory's one-cycle latency; in-flight reads tracked for credit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr_d1 <= ADDR_W'(0);
      r_rd_inflight <= 2'd0;
    end else begin
      r_mem_addr_d1 <= r_mem_addr;
      case ({w_rd_issue, bus.mem_valid_out})
        2'b10:   r_rd_inflight <= r_rd_inflight + 2'd1;
        2'b01:   r_rd_inflight <= r_rd_inflight - 2'd1;
        default: r_rd_inflight <= r_rd_inflight;
      endcase
    end
  end

  assign w_rsp_in.addr  = r_mem_addr_d1;
  assign w_rsp_in.rdata = bus.mem_data_out;
  assign w_rsp_pop      = !w_rsp_empty && bus.rsp_ready;

  sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.mem_valid_out),
    .i_pop   (w_rsp_pop),
    .i_wdata (w_rsp_in),
    .o_rdata (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

  assign bus.rsp_valid      = !w_rsp_empty;
  assign bus.rsp_rdata      = w_rsp_head.rdata;
  assign bus.rsp_addr       = w_rsp_head.addr;
  assign bus.mem_enable     = r_mem_enable;
  assign bus.mem_read_write = r_mem_rw;
  assign bus.mem_address    = r_mem_addr;
  assign bus.mem_data_in    = r_mem_wdata;
  assign bus.busy           = (w_cmd_count != CCW'(0)) || (r_rd_inflight != 2'd0) || r_mem_enable;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: 16x32 memory stand-in, array/queue reference model, directed and random steps.
module tb_mem_req_ctrl;
  import mem_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_req_ctrl_if bus_if ();

  mem_req_ctrl #(.CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Memory stand-in: one-cycle read latency, writes commit on the enable edge, cleared by rst.
  logic [DATA_W-1:0] mem_arr [MEM_DEPTH];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_arr[i] <= '0;
      bus_if.mem_valid_out <= 1'b0;
      bus_if.mem_data_out  <= '0;
    end else begin
      bus_if.mem_valid_out <= 1'b0;
      if (bus_if.mem_enable) begin
        if (bus_if.mem_read_write) mem_arr[bus_if.mem_address] <= bus_if.mem_data_in;
        else begin
          bus_if.mem_data_out  <= mem_arr[bus_if.mem_address];
          bus_if.mem_valid_out <= 1'b1;
        end
      end
    end
  end

  logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
  exp_t              exp_q [$];
  logic [DATA_W-1:0] got_q [$];
  int checks = 0, failures = 0, resp_cnt = 0, en_cnt = 0, rd_run = 0, rd_run_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: update the reference model from the handshakes visible now, then advance.
  task automatic tick();
    logic acc, take, ovf;
    exp_t e;
    acc  = bus_if.req_valid && bus_if.req_ready;
    take = bus_if.rsp_valid && bus_if.rsp_ready;
    ovf  = bus_if.mem_valid_out && dut.w_rsp_full && !take;
    chk("rsp_no_overflow", ovf, 0);
    if (take) begin
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_addr", bus_if.rsp_addr, e.a);
        chk("rsp_rdata", bus_if.rsp_rdata, e.d);
      end
      got_q.push_back(bus_if.rsp_rdata);
      resp_cnt++;
    end
    if (acc) begin
      if (bus_if.req_write) ref_mem[bus_if.req_addr] = bus_if.req_wdata;
      else begin
        e.a = bus_if.req_addr;
        e.d = ref_mem[bus_if.req_addr];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (bus_if.mem_enable) en_cnt++;
    if (bus_if.mem_enable && !bus_if.mem_read_write) rd_run++;
    else rd_run = 0;
    if (rd_run > rd_run_max) rd_run_max = rd_run;
  endtask

  task automatic send(input logic w, input int a, input logic [DATA_W-1:0] d);
    logic rdy;
    rdy = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = ADDR_W'(a);
    bus_if.req_wdata = d;
    for (int k = 0; k < 50; k++) begin
      rdy = bus_if.req_ready;
      tick();
      if (rdy) break;
    end
    chk("req_accepted", rdy, 1);
    bus_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    bus_if.rsp_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      done = (exp_q.size() == 0) && !bus_if.busy && !bus_if.rsp_valid;
      if (done) break;
      tick();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus_if.req_ready, 0);
    chk({tag, "_mem_en"}, bus_if.mem_enable, 0);
    chk({tag, "_mem_rw"}, bus_if.mem_read_write, 0);
    chk({tag, "_mem_addr"}, bus_if.mem_address, 0);
    chk({tag, "_mem_din"}, bus_if.mem_data_in, 0);
    chk({tag, "_rsp_valid"}, bus_if.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus_if.rsp_rdata, 0);
    chk({tag, "_rsp_addr"}, bus_if.rsp_addr, 0);
    chk({tag, "_busy"}, bus_if.busy, 0);
  endtask

  initial begin
    int lat, r0, n, ra;
    logic rdy;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;

    // Reset state and release.
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();
    chk("req_ready_after_reset", bus_if.req_ready, 1);

    // Idle pipe stays quiet.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_mem_en", bus_if.mem_enable, 0);
      chk("idle_busy", bus_if.busy, 0);
      chk("idle_rsp_valid", bus_if.rsp_valid, 0);
    end

    // Write then read addr 3; response three cycles after the read is accepted.
    bus_if.rsp_ready = 1'b1;
    send(1'b1, 3, 32'hDEADBEEF);
    r0 = resp_cnt;
    got_q.delete();
    send(1'b0, 3, 32'h0);
    lat = 0;
    while (!bus_if.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("rd_latency", lat, 3);
    drain();
    chk("raw3_count", resp_cnt - r0, 1);
    chk("raw3_data", got_q.size() != 0 ? got_q[0] : 32'h0, 32'hDEADBEEF);

    // Eight back-to-back reads stream with enable held high.
    for (int i = 0; i < 8; i++) send(1'b1, i, 32'(i) * 32'h11111111);
    got_q.delete();
    rd_run_max = 0;
    for (int i = 0; i < 8; i++) send(1'b0, i, 32'h0);
    drain();
    chk("b2b_enable_run", rd_run_max, 8);
    chk("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("b2b_data", i < got_q.size() ? got_q[i] : 32'h0, 32'(i) * 32'h11111111);

    // Backpressure: credit stops issue at four reads, command queue fills, head held.
    bus_if.rsp_ready = 1'b0;
    got_q.delete();
    en_cnt = 0;
    n = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus_if.req_addr = ADDR_W'((n + 1) % 8);
      rdy = bus_if.req_ready;
      tick();
      if (rdy) n++;
      if (bus_if.rsp_valid)
        chk("bp_head_held", bus_if.rsp_rdata, exp_q.size() != 0 ? exp_q[0].d : 32'h0);
    end
    chk("bp_accepted", n, 8);
    chk("bp_req_ready_low", bus_if.req_ready, 0);
    chk("bp_issued", en_cnt, 4);
    chk("bp_rsp_valid", bus_if.rsp_valid, 1);
    bus_if.req_valid = 1'b0;
    drain();
    chk("bp_count", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("bp_order", k < got_q.size() ? got_q[k] : 32'h0, 32'((k + 1) % 8) * 32'h11111111);

    // Read-after-write interleave on addr 5.
    got_q.delete();
    send(1'b1, 5, 32'h1);
    send(1'b0, 5, 32'h0);
    send(1'b1, 5, 32'h2);
    send(1'b0, 5, 32'h0);
    drain();
    chk("raw5_count", got_q.size(), 2);
    chk("raw5_first", got_q.size() > 0 ? got_q[0] : 32'h0, 32'h1);
    chk("raw5_second", got_q.size() > 1 ? got_q[1] : 32'h0, 32'h2);

    // Random traffic with random response backpressure.
    for (int i = 0; i < 200; i++) begin
      bus_if.rsp_ready = ($urandom_range(0, 3) != 0);
      bus_if.req_valid = ($urandom_range(0, 2) != 0);
      bus_if.req_write = 1'($urandom_range(0, 1));
      bus_if.req_addr  = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
      bus_if.req_wdata = $urandom;
      tick();
    end
    bus_if.req_valid = 1'b0;
    drain();

    // Reset with two reads in flight drops them and clears the memory.
    send(1'b0, 1, 32'h0);
    send(1'b0, 2, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    r0 = resp_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_no_rsp", bus_if.rsp_valid, 0);
    end
    chk("post_rst_rsp_count", resp_cnt - r0, 0);
    ra = $urandom_range(0, MEM_DEPTH - 1);
    got_q.delete();
    send(1'b0, ra, 32'h0);
    drain();
    chk("post_rst_count", got_q.size(), 1);
    chk("post_rst_data", got_q.size() != 0 ? got_q[0] : 32'hFFFFFFFF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
